// File: rtl/wallace_product_accumulator.sv
// Multiply-accumulate back end: registers each 16-bit Wallace-tree product, sums it into a
// wide accumulator, and presents the framed result on a valid/ready handshake.
module wallace_product_accumulator #(
    parameter int ACC_W     = 24,
    parameter int CNT_W     = 9,
    parameter int MAX_TERMS = 256,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_count,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [15:0]      p_reg;
    logic             p_vld, p_last;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf, out_vld;
    logic             accept, eff_last, handshake;
    logic [ACC_W:0]   sum;
    logic [CNT_W:0]   pending;

    assign in_ready  = (state == IDLE) || (state == RUN);
    assign accept    = in_valid && in_ready;
    assign handshake = out_vld && out_ready;

    // Terms already summed plus the one in the stage register plus this one; one bit
    // wider than the counter so the term-limit compare never wraps.
    assign pending  = {1'b0, cnt} + (CNT_W+1)'(p_vld) + (CNT_W+1)'(1);
    assign eff_last = in_last || (int'(pending) == MAX_TERMS);

    assign sum = {1'b0, acc} + (ACC_W+1)'(p_reg);

    // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = eff_last ? DRAIN : RUN;
            RUN:     if (accept && eff_last) state_nxt = DRAIN;
            DRAIN:   if (p_vld && p_last) state_nxt = DONE;
            DONE:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Input register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg  <= '0;
            p_vld  <= 1'b0;
            p_last <= 1'b0;
        end else begin
            if (accept) p_reg <= prod_bits;
            p_vld  <= accept;
            p_last <= accept && eff_last;
        end
    end

    // Accumulate stage; the handshake and a pending term can never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= (state == DONE) && !handshake;
            if (handshake) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (p_vld) begin
                cnt <= cnt + CNT_W'(1);
                if (sum[ACC_W]) begin
                    ovf <= 1'b1;
                    acc <= SATURATE ? '1 : sum[ACC_W-1:0];
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end
        end
    end

    assign out_valid  = out_vld;
    assign acc_out    = acc;
    assign term_count = cnt;
    assign overflow   = ovf;

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Directed bench: three 256-term instances (24-bit wrap, 16-bit wrap, 16-bit clamp) share
// stimulus and a scoreboard; a fourth instance with a 3-term limit covers term framing.
module tb_wallace_product_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] prod_bits = '0;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [23:0] a_acc;
    logic [8:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [15:0] b_acc;
    logic [8:0]  b_cnt;
    logic        c_in_ready, c_out_valid, c_ovf;
    logic [15:0] c_acc;
    logic [8:0]  c_cnt;

    logic        m_in_valid = 1'b0, m_in_last = 1'b0, m_out_ready = 1'b0;
    logic [15:0] m_prod = '0;
    logic        m_in_ready, m_out_valid, m_ovf;
    logic [23:0] m_acc;
    logic [8:0]  m_cnt;

    wallace_product_accumulator #(.ACC_W(24), .CNT_W(9), .MAX_TERMS(256), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .prod_bits(prod_bits), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .acc_out(a_acc), .term_count(a_cnt), .overflow(a_ovf));

    wallace_product_accumulator #(.ACC_W(16), .CNT_W(9), .MAX_TERMS(256), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .prod_bits(prod_bits), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .acc_out(b_acc), .term_count(b_cnt), .overflow(b_ovf));

    wallace_product_accumulator #(.ACC_W(16), .CNT_W(9), .MAX_TERMS(256), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .prod_bits(prod_bits), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .acc_out(c_acc), .term_count(c_cnt), .overflow(c_ovf));

    wallace_product_accumulator #(.ACC_W(24), .CNT_W(9), .MAX_TERMS(3), .SATURATE(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .prod_bits(m_prod), .in_last(m_in_last), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .acc_out(m_acc), .term_count(m_cnt), .overflow(m_ovf));

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] acc24;
        logic [15:0] acc16w;
        logic [15:0] acc16s;
        logic        o24;
        logic        o16;
        int          cnt;
    } exp_t;

    exp_t sb[$];

    longint m24, m16w, m16s;
    bit     mo24, mo16;
    int     mcnt;

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m24 = 0; m16w = 0; m16s = 0; mo24 = 0; mo16 = 0; mcnt = 0;
    endtask

    task automatic model_add(input logic [15:0] p);
        m24 += p;
        if (m24 >= 64'd16777216) begin mo24 = 1; m24 -= 64'd16777216; end
        m16w += p;
        if (m16w >= 64'd65536) begin mo16 = 1; m16w -= 64'd65536; end
        m16s += p;
        if (m16s > 64'd65535) m16s = 64'd65535;
        mcnt++;
    endtask

    // Hold the product until the shared instances accept it, then update the model.
    task automatic send(input logic [15:0] p, input logic last);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1; prod_bits = p; in_last = last;
        while (!a_in_ready && n < 50) begin tick(); n++; end
        if (!a_in_ready) begin
            check("send_ready_timeout", a_in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        model_add(p);
        if (last) begin
            e.acc24 = m24[23:0]; e.acc16w = m16w[15:0]; e.acc16s = m16s[15:0];
            e.o24 = mo24; e.o16 = mo16; e.cnt = mcnt;
            sb.push_back(e);
            model_clear();
        end
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input int hold);
        int   n = 0;
        exp_t e;
        while (!a_out_valid && n < 20) begin tick(); n++; end
        check({tag, "_valid"}, a_out_valid, 1);
        if (!a_out_valid) return;
        if (sb.size() == 0) begin
            n_total++; n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard required one entry", tag);
            return;
        end
        e = sb.pop_front();
        if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
        check({tag, "_acc24"}, a_acc, e.acc24);
        check({tag, "_cnt"}, a_cnt, e.cnt);
        check({tag, "_ovf24"}, a_ovf, e.o24);
        check({tag, "_acc16w"}, b_acc, e.acc16w);
        check({tag, "_ovf16w"}, b_ovf, e.o16);
        check({tag, "_acc16s"}, c_acc, e.acc16s);
        check({tag, "_ovf16s"}, c_ovf, e.o16);
        check({tag, "_in_ready_done"}, a_in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, a_out_valid, 1);
            check({tag, "_hold_in_ready"}, a_in_ready, 0);
            check({tag, "_hold_acc"}, a_acc, e.acc24);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, a_out_valid, 0);
        check({tag, "_post_in_ready"}, a_in_ready, 1);
        check({tag, "_post_acc"}, a_acc, 0);
        check({tag, "_post_cnt"}, a_cnt, 0);
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_acc", a_acc, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_ovf", a_ovf, 0);
        rst_n = 1'b1;
        tick();

        // Four full-scale products back to back, last on the fourth
        for (int i = 0; i < 4; i++) send(16'hFE01, i == 3);
        wait_result("t1", 2, 0);

        // Single-term accumulation held in DONE while downstream stalls
        send(16'h0001, 1'b1);
        wait_result("t2", 2, 10);

        // Overflow in the 16-bit instances: wrap versus clamp
        send(16'd65025, 1'b0);
        send(16'd65025, 1'b1);
        wait_result("t3", -1, 0);

        // Term limit of three with the fourth product held off until after the handshake
        m_in_valid = 1'b1; m_in_last = 1'b0; m_prod = 16'd10;
        tick();
        m_prod = 16'd20;
        tick();
        m_prod = 16'd30;
        tick();
        m_prod = 16'd40;
        check("t4_drain_in_ready", m_in_ready, 0);
        tick();
        check("t4_done_in_ready", m_in_ready, 0);
        tick();
        check("t4_valid", m_out_valid, 1);
        check("t4_acc", m_acc, 60);
        check("t4_cnt", m_cnt, 3);
        check("t4_ovf", m_ovf, 0);
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
        check("t4_post_valid", m_out_valid, 0);
        check("t4_post_acc", m_acc, 0);
        check("t4_post_in_ready", m_in_ready, 1);
        tick();
        m_prod = 16'd1; m_in_last = 1'b1;
        tick();
        m_in_valid = 1'b0; m_in_last = 1'b0;
        tick();
        tick();
        check("t4b_valid", m_out_valid, 1);
        check("t4b_acc", m_acc, 41);
        check("t4b_cnt", m_cnt, 2);
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;

        // Gapped input: valid every other cycle, products 1..8
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), i == 8);
            tick();
        end
        wait_result("t5", -1, 0);

        // Asynchronous reset between clock edges while in RUN
        send(16'd7, 1'b0);
        send(16'd9, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_acc", a_acc, 0);
        check("t6_rst_cnt", a_cnt, 0);
        check("t6_rst_valid", a_out_valid, 0);
        check("t6_rst_in_ready", a_in_ready, 1);
        check("t6_rst_ovf", a_ovf, 0);
        #2;
        rst_n = 1'b1;
        model_clear();
        tick();
        send(16'd3, 1'b0);
        send(16'd5, 1'b1);
        wait_result("t6", 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
